// File: rtl/jtgng_dwnld.sv
// ROM download router: steers the ioctl byte stream to SDRAM word writes or PROM strobes.
// Define JTGNG_DWNLD_CHECKSUM_EN to add a running 16-bit byte checksum output (chksum).
module jtgng_dwnld #(
    parameter logic [21:0] PROM_START = 22'h1_8000,
    parameter int unsigned PROM_AW    = 10,
    localparam int unsigned AW        = 22,
    localparam int unsigned DW        = 8,
    localparam int unsigned MW        = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               downloading,
    input  logic [AW-1:0]      ioctl_addr,
    input  logic [DW-1:0]      ioctl_data,
    input  logic               ioctl_wr,
    output logic [AW-1:0]      prog_addr,
    output logic [DW-1:0]      prog_data,
    output logic [MW-1:0]      prog_mask,
    output logic               prog_we,
    input  logic               prog_ack,
    output logic               prom_we,
    output logic [PROM_AW-1:0] prom_addr,
    output logic [DW-1:0]      prom_data,
    output logic               overrun,
    output logic               dwnld_done
`ifdef JTGNG_DWNLD_CHECKSUM_EN
    ,
    output logic [15:0]        chksum
`endif
);

    typedef enum logic {
        IDLE,
        WAIT_ACK
    } state_e;

    state_e               state_q, state_d;
    logic                 prog_we_q, prog_we_d;
    logic [AW-1:0]        prog_addr_q, prog_addr_d;
    logic [DW-1:0]        prog_data_q, prog_data_d;
    logic [MW-1:0]        prog_mask_q, prog_mask_d;
    logic                 pend_v_q, pend_v_d;
    logic [AW-1:0]        pend_addr_q, pend_addr_d;
    logic [DW-1:0]        pend_data_q, pend_data_d;
    logic [MW-1:0]        pend_mask_q, pend_mask_d;
    logic                 prom_we_q, prom_we_d;
    logic [PROM_AW-1:0]   prom_addr_q, prom_addr_d;
    logic [DW-1:0]        prom_data_q, prom_data_d;
    logic                 overrun_q, overrun_d;
    logic                 done_q, done_d;
    logic                 arm_q, arm_d;
    logic                 dl_q;

    logic                 accept_c, is_prom_c, sdram_c, ack_c, gap_c, drop_c;
    logic                 rise_c, fall_c, fire_c;
    logic [AW-1:0]        word_addr_c;
    logic [MW-1:0]        byte_mask_c;

    assign accept_c    = ioctl_wr & downloading;
    assign is_prom_c   = (ioctl_addr >= PROM_START);
    assign sdram_c     = accept_c & ~is_prom_c;
    // Ack only counts while a request is actually on the bus; the reissue gap ignores it.
    assign ack_c       = (state_q == WAIT_ACK) & prog_we_q & prog_ack;
    assign gap_c       = (state_q == WAIT_ACK) & ~prog_we_q;
    assign drop_c      = sdram_c & (state_q == WAIT_ACK) & ~ack_c & pend_v_q;
    assign word_addr_c = {1'b0, ioctl_addr[AW-1:1]};
    assign byte_mask_c = ioctl_addr[0] ? 2'b01 : 2'b10;
    assign rise_c      = downloading & ~dl_q;
    assign fall_c      = ~downloading & dl_q;
    assign fire_c      = arm_q & (state_q == IDLE) & ~pend_v_q & ~downloading;

    // Next-state and output logic
    always_comb begin
        state_d     = state_q;
        prog_we_d   = prog_we_q;
        prog_addr_d = prog_addr_q;
        prog_data_d = prog_data_q;
        prog_mask_d = prog_mask_q;
        pend_v_d    = pend_v_q;
        pend_addr_d = pend_addr_q;
        pend_data_d = pend_data_q;
        pend_mask_d = pend_mask_q;
        prom_we_d   = 1'b0;
        prom_addr_d = prom_addr_q;
        prom_data_d = prom_data_q;
        overrun_d   = overrun_q | drop_c;
        done_d      = fire_c;
        arm_d       = arm_q;

        if (accept_c && is_prom_c) begin
            prom_we_d   = 1'b1;
            prom_addr_d = PROM_AW'(ioctl_addr - PROM_START);
            prom_data_d = ioctl_data;
        end

        case (state_q)
            IDLE: begin
                if (sdram_c) begin
                    prog_we_d   = 1'b1;
                    prog_addr_d = word_addr_c;
                    prog_data_d = ioctl_data;
                    prog_mask_d = byte_mask_c;
                    state_d     = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (ack_c) begin
                    prog_we_d = 1'b0;
                    // Stage the next write now; the gap cycle that follows reasserts prog_we.
                    if (pend_v_q) begin
                        prog_addr_d = pend_addr_q;
                        prog_data_d = pend_data_q;
                        prog_mask_d = pend_mask_q;
                        pend_v_d    = sdram_c;
                        if (sdram_c) begin
                            pend_addr_d = word_addr_c;
                            pend_data_d = ioctl_data;
                            pend_mask_d = byte_mask_c;
                        end
                    end else if (sdram_c) begin
                        prog_addr_d = word_addr_c;
                        prog_data_d = ioctl_data;
                        prog_mask_d = byte_mask_c;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    if (gap_c) begin
                        prog_we_d = 1'b1;
                    end
                    if (sdram_c && !pend_v_q) begin
                        pend_v_d    = 1'b1;
                        pend_addr_d = word_addr_c;
                        pend_data_d = ioctl_data;
                        pend_mask_d = byte_mask_c;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (fire_c) begin
            arm_d = 1'b0;
        end
        if (fall_c) begin
            arm_d = 1'b1;
        end
        if (rise_c) begin
            arm_d = 1'b0;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            prog_we_q   <= 1'b0;
            prog_addr_q <= '0;
            prog_data_q <= '0;
            prog_mask_q <= 2'b11;
            pend_v_q    <= 1'b0;
            pend_addr_q <= '0;
            pend_data_q <= '0;
            pend_mask_q <= 2'b11;
            prom_we_q   <= 1'b0;
            prom_addr_q <= '0;
            prom_data_q <= '0;
            overrun_q   <= 1'b0;
            done_q      <= 1'b0;
            arm_q       <= 1'b0;
            dl_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            prog_we_q   <= prog_we_d;
            prog_addr_q <= prog_addr_d;
            prog_data_q <= prog_data_d;
            prog_mask_q <= prog_mask_d;
            pend_v_q    <= pend_v_d;
            pend_addr_q <= pend_addr_d;
            pend_data_q <= pend_data_d;
            pend_mask_q <= pend_mask_d;
            prom_we_q   <= prom_we_d;
            prom_addr_q <= prom_addr_d;
            prom_data_q <= prom_data_d;
            overrun_q   <= overrun_d;
            done_q      <= done_d;
            arm_q       <= arm_d;
            dl_q        <= downloading;
        end
    end

    assign prog_we    = prog_we_q;
    assign prog_addr  = prog_addr_q;
    assign prog_data  = prog_data_q;
    assign prog_mask  = prog_mask_q;
    assign prom_we    = prom_we_q;
    assign prom_addr  = prom_addr_q;
    assign prom_data  = prom_data_q;
    assign overrun    = overrun_q;
    assign dwnld_done = done_q;

`ifdef JTGNG_DWNLD_CHECKSUM_EN
    logic [15:0] sum_q, sum_d;

    // Sum of every byte that was actually delivered, restarted per download
    always_comb begin
        sum_d = sum_q;
        if (rise_c) begin
            sum_d = '0;
        end
        if (accept_c && !drop_c) begin
            sum_d = sum_d + 16'(ioctl_data);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign chksum = sum_q;
`endif

endmodule

// File: tb/tb_jtgng_dwnld.sv
// Bench for jtgng_dwnld: directed scenarios plus randomized traffic against a queue-based model.
module tb_jtgng_dwnld;

    logic        clk;
    logic        rst_n;
    logic        downloading;
    logic [21:0] ioctl_addr;
    logic [7:0]  ioctl_data;
    logic        ioctl_wr;
    logic [21:0] prog_addr;
    logic [7:0]  prog_data;
    logic [1:0]  prog_mask;
    logic        prog_we;
    logic        prog_ack;
    logic        prom_we;
    logic [9:0]  prom_addr;
    logic [7:0]  prom_data;
    logic        overrun;
    logic        dwnld_done;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [21:0] a;
        logic [7:0]  d;
        logic [1:0]  m;
    } wr_t;

    jtgng_dwnld #(.PROM_START(22'h1_8000), .PROM_AW(10)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .downloading(downloading),
        .ioctl_addr (ioctl_addr),
        .ioctl_data (ioctl_data),
        .ioctl_wr   (ioctl_wr),
        .prog_addr  (prog_addr),
        .prog_data  (prog_data),
        .prog_mask  (prog_mask),
        .prog_we    (prog_we),
        .prog_ack   (prog_ack),
        .prom_we    (prom_we),
        .prom_addr  (prom_addr),
        .prom_data  (prom_data),
        .overrun    (overrun),
        .dwnld_done (dwnld_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one byte for one clock; returns at the negedge after it was sampled.
    task automatic send(input logic [21:0] a, input logic [7:0] d);
        ioctl_addr = a;
        ioctl_data = d;
        ioctl_wr   = 1'b1;
        @(negedge clk);
        ioctl_wr   = 1'b0;
    endtask

    task automatic ack_pulse();
        prog_ack = 1'b1;
        @(negedge clk);
        prog_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; downloading = 1'b0; ioctl_wr = 1'b0; prog_ack = 1'b0;
        ioctl_addr = '0; ioctl_data = '0;
        repeat (2) @(negedge clk);
        checks++; if (prog_we !== 1'b0) begin errors++; $display("FAIL reset_prog_we got=%b exp=0", prog_we); end
        checks++; if (prom_we !== 1'b0) begin errors++; $display("FAIL reset_prom_we got=%b exp=0", prom_we); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
        checks++; if (dwnld_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", dwnld_done); end
        checks++; if (prog_mask !== 2'b11) begin errors++; $display("FAIL reset_mask got=%b exp=11", prog_mask); end
        checks++; if (prog_addr !== 22'h0) begin errors++; $display("FAIL reset_prog_addr got=%h exp=0", prog_addr); end
        checks++; if (prog_data !== 8'h0) begin errors++; $display("FAIL reset_prog_data got=%h exp=0", prog_data); end
        checks++; if (prom_addr !== 10'h0) begin errors++; $display("FAIL reset_prom_addr got=%h exp=0", prom_addr); end
        rst_n = 1'b1;
        downloading = 1'b1;
        @(negedge clk);
        checks++; if (prog_we !== 1'b0) begin errors++; $display("FAIL reset_release_we got=%b exp=0", prog_we); end
    endtask

    task automatic test_single_write();
        send(22'h000003, 8'hA5);
        checks++; if (prog_we !== 1'b1) begin errors++; $display("FAIL single_we got=%b exp=1", prog_we); end
        checks++; if (prog_addr !== 22'h000001) begin errors++; $display("FAIL single_addr got=%h exp=000001", prog_addr); end
        checks++; if (prog_mask !== 2'b01) begin errors++; $display("FAIL single_mask got=%b exp=01", prog_mask); end
        checks++; if (prog_data !== 8'hA5) begin errors++; $display("FAIL single_data got=%h exp=a5", prog_data); end
        repeat (3) @(negedge clk);
        checks++; if (prog_we !== 1'b1 || prog_addr !== 22'h000001) begin errors++; $display("FAIL single_hold we=%b addr=%h exp we=1 addr=000001", prog_we, prog_addr); end
        ack_pulse();
        checks++; if (prog_we !== 1'b0) begin errors++; $display("FAIL single_drop got=%b exp=0", prog_we); end
        @(negedge clk);
    endtask

    task automatic test_pending();
        send(22'h000010, 8'h61);
        checks++; if (prog_we !== 1'b1 || prog_mask !== 2'b10 || prog_addr !== 22'h8) begin errors++; $display("FAIL pend_first we=%b mask=%b addr=%h exp 1/10/8", prog_we, prog_mask, prog_addr); end
        @(negedge clk);
        send(22'h000011, 8'h62);
        checks++; if (prog_data !== 8'h61 || prog_mask !== 2'b10) begin errors++; $display("FAIL pend_hold data=%h mask=%b exp 61/10", prog_data, prog_mask); end
        repeat (3) @(negedge clk);
        ack_pulse();
        checks++; if (prog_we !== 1'b0) begin errors++; $display("FAIL pend_gap got=%b exp=0", prog_we); end
        @(negedge clk);
        checks++; if (prog_we !== 1'b1) begin errors++; $display("FAIL pend_reissue_we got=%b exp=1", prog_we); end
        checks++; if (prog_addr !== 22'h8 || prog_mask !== 2'b01 || prog_data !== 8'h62) begin errors++; $display("FAIL pend_reissue addr=%h mask=%b data=%h exp 8/01/62", prog_addr, prog_mask, prog_data); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL pend_overrun got=%b exp=0", overrun); end
        ack_pulse();
        @(negedge clk);
        checks++; if (prog_we !== 1'b0) begin errors++; $display("FAIL pend_idle got=%b exp=0", prog_we); end
    endtask

    task automatic test_overrun();
        ioctl_wr = 1'b1;
        ioctl_addr = 22'h20; ioctl_data = 8'hB1; @(negedge clk);
        ioctl_addr = 22'h21; ioctl_data = 8'hB2; @(negedge clk);
        ioctl_addr = 22'h22; ioctl_data = 8'hB3; @(negedge clk);
        ioctl_wr = 1'b0;
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag got=%b exp=1", overrun); end
        checks++; if (prog_we !== 1'b1 || prog_addr !== 22'h10 || prog_data !== 8'hB1 || prog_mask !== 2'b10) begin errors++; $display("FAIL ovr_first we=%b addr=%h data=%h mask=%b exp 1/10/b1/10", prog_we, prog_addr, prog_data, prog_mask); end
        ack_pulse();
        @(negedge clk);
        checks++; if (prog_we !== 1'b1 || prog_data !== 8'hB2 || prog_mask !== 2'b01) begin errors++; $display("FAIL ovr_second we=%b data=%h mask=%b exp 1/b2/01", prog_we, prog_data, prog_mask); end
        ack_pulse();
        repeat (2) @(negedge clk);
        checks++; if (prog_we !== 1'b0) begin errors++; $display("FAIL ovr_third_dropped got=%b exp=0", prog_we); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky got=%b exp=1", overrun); end
    endtask

    task automatic test_prom();
        send(22'h000040, 8'h11);
        send(22'h018005, 8'h3C);
        checks++; if (prom_we !== 1'b1 || prom_addr !== 10'h005 || prom_data !== 8'h3C) begin errors++; $display("FAIL prom_strobe we=%b addr=%h data=%h exp 1/005/3c", prom_we, prom_addr, prom_data); end
        checks++; if (prog_we !== 1'b1 || prog_addr !== 22'h20 || prog_data !== 8'h11) begin errors++; $display("FAIL prom_sdram_held we=%b addr=%h data=%h exp 1/20/11", prog_we, prog_addr, prog_data); end
        @(negedge clk);
        checks++; if (prom_we !== 1'b0) begin errors++; $display("FAIL prom_one_cycle got=%b exp=0", prom_we); end
        ack_pulse();
        @(negedge clk);
        send(22'h017FFF, 8'h77);
        checks++; if (prom_we !== 1'b0 || prog_we !== 1'b1 || prog_addr !== 22'h00BFFF || prog_mask !== 2'b01) begin errors++; $display("FAIL prom_below prom_we=%b we=%b addr=%h mask=%b exp 0/1/00bfff/01", prom_we, prog_we, prog_addr, prog_mask); end
        ack_pulse();
        @(negedge clk);
        send(22'h018000, 8'h5A);
        checks++; if (prom_we !== 1'b1 || prom_addr !== 10'h000 || prog_we !== 1'b0) begin errors++; $display("FAIL prom_start prom_we=%b addr=%h we=%b exp 1/000/0", prom_we, prom_addr, prog_we); end
    endtask

    task automatic test_done();
        send(22'h000050, 8'h22);
        downloading = 1'b0;
        @(negedge clk);
        checks++; if (dwnld_done !== 1'b0) begin errors++; $display("FAIL done_early got=%b exp=0", dwnld_done); end
        send(22'h018001, 8'h99);
        checks++; if (prom_we !== 1'b0) begin errors++; $display("FAIL done_ignore_wr got=%b exp=0", prom_we); end
        send(22'h000004, 8'h33);
        repeat (2) @(negedge clk);
        checks++; if (dwnld_done !== 1'b0 || prog_we !== 1'b1) begin errors++; $display("FAIL done_wait done=%b we=%b exp 0/1", dwnld_done, prog_we); end
        ack_pulse();
        checks++; if (dwnld_done !== 1'b0 || prog_we !== 1'b0) begin errors++; $display("FAIL done_ack done=%b we=%b exp 0/0", dwnld_done, prog_we); end
        @(negedge clk);
        checks++; if (dwnld_done !== 1'b1) begin errors++; $display("FAIL done_pulse got=%b exp=1", dwnld_done); end
        checks++; if (prog_we !== 1'b0) begin errors++; $display("FAIL done_no_extra_write got=%b exp=0", prog_we); end
        @(negedge clk);
        checks++; if (dwnld_done !== 1'b0) begin errors++; $display("FAIL done_single got=%b exp=0", dwnld_done); end
        downloading = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_write();
        send(22'h000060, 8'h44);
        send(22'h000061, 8'h45);
        rst_n = 1'b0;
        #1;
        checks++; if (prog_we !== 1'b0 || prom_we !== 1'b0 || dwnld_done !== 1'b0) begin errors++; $display("FAIL rst_mid_strobes we=%b prom=%b done=%b exp 0/0/0", prog_we, prom_we, dwnld_done); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rst_mid_overrun got=%b exp=0", overrun); end
        checks++; if (prog_mask !== 2'b11 || prog_addr !== 22'h0 || prog_data !== 8'h0 || prom_addr !== 10'h0) begin errors++; $display("FAIL rst_mid_values mask=%b addr=%h data=%h paddr=%h exp 11/0/0/0", prog_mask, prog_addr, prog_data, prom_addr); end
        @(negedge clk);
        rst_n = 1'b1;
        ack_pulse();
        checks++; if (prog_we !== 1'b0) begin errors++; $display("FAIL rst_mid_ack got=%b exp=0", prog_we); end
        repeat (3) @(negedge clk);
        checks++; if (prog_we !== 1'b0) begin errors++; $display("FAIL rst_mid_quiet got=%b exp=0", prog_we); end
    endtask

    task automatic test_random();
        wr_t         mq[$];
        wr_t         e;
        bit          we_exp = 1'b0, reissue = 1'b0, ovr_exp = 1'b0, arm = 1'b0, prev_dl = 1'b0;
        bit          prom_exp = 1'b0, done_exp = 1'b0, ack_now, dl = 1'b0, wr, ak;
        logic [9:0]  prom_a_exp = '0;
        logic [7:0]  prom_d_exp = '0;
        logic [21:0] a;
        logic [7:0]  d;

        rst_n = 1'b0; downloading = 1'b0; ioctl_wr = 1'b0; prog_ack = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            checks++; if (prog_we !== we_exp) begin errors++; $display("FAIL rnd_prog_we cyc=%0d got=%b exp=%b", c, prog_we, we_exp); end
            if (we_exp && mq.size() > 0) begin
                checks++;
                if (prog_addr !== mq[0].a || prog_data !== mq[0].d || prog_mask !== mq[0].m) begin
                    errors++;
                    $display("FAIL rnd_prog_payload cyc=%0d got=%h/%h/%b exp=%h/%h/%b", c, prog_addr, prog_data, prog_mask, mq[0].a, mq[0].d, mq[0].m);
                end
            end
            checks++; if (prom_we !== prom_exp) begin errors++; $display("FAIL rnd_prom_we cyc=%0d got=%b exp=%b", c, prom_we, prom_exp); end
            if (prom_exp) begin
                checks++; if (prom_addr !== prom_a_exp || prom_data !== prom_d_exp) begin errors++; $display("FAIL rnd_prom_payload cyc=%0d got=%h/%h exp=%h/%h", c, prom_addr, prom_data, prom_a_exp, prom_d_exp); end
            end
            checks++; if (overrun !== ovr_exp) begin errors++; $display("FAIL rnd_overrun cyc=%0d got=%b exp=%b", c, overrun, ovr_exp); end
            checks++; if (dwnld_done !== done_exp) begin errors++; $display("FAIL rnd_done cyc=%0d got=%b exp=%b", c, dwnld_done, done_exp); end

            if (c == 0 || $urandom_range(99) < 3) dl = !dl;
            wr = ($urandom_range(99) < 50);
            if ($urandom_range(99) < 70) a = 22'($urandom_range(32'h17FFF, 0));
            else                         a = 22'($urandom_range(32'h3FFFFF, 32'h18000));
            d  = 8'($urandom);
            ak = ($urandom_range(99) < 30);
            downloading = dl; ioctl_wr = wr; ioctl_addr = a; ioctl_data = d; prog_ack = ak;

            // Model: at most two SDRAM bytes in flight; an ack frees a slot in the same cycle.
            done_exp = arm && (mq.size() == 0) && !dl;
            if (done_exp) arm = 1'b0;
            if (prev_dl && !dl) arm = 1'b1;
            if (!prev_dl && dl) arm = 1'b0;
            prev_dl = dl;
            ack_now = we_exp && ak;
            if (ack_now) mq.delete(0);
            prom_exp = 1'b0;
            if (wr && dl) begin
                if (a >= 22'h18000) begin
                    prom_exp   = 1'b1;
                    prom_a_exp = 10'((int'(a) - 'h18000) % 1024);
                    prom_d_exp = d;
                end else if (mq.size() >= 2) begin
                    ovr_exp = 1'b1;
                end else begin
                    e.a = 22'(a / 2);
                    e.d = d;
                    e.m = (a % 2 == 1) ? 2'b01 : 2'b10;
                    mq.push_back(e);
                end
            end
            if (ack_now) begin
                we_exp  = 1'b0;
                reissue = (mq.size() > 0);
            end else if (!we_exp) begin
                we_exp  = reissue || (mq.size() > 0);
                reissue = 1'b0;
            end
        end
        ioctl_wr = 1'b0;
        prog_ack = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_pending();
        test_overrun();
        test_prom();
        test_done();
        test_reset_mid_write();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/jtgng_dwnld.md
JTGNG_DWNLD -- requirements
Module: jtgng_dwnld

Interface
REQ-001 SHALL have parameter PROM_START, 22'h1_8000, first byte address routed to PROM strobes instead of SDRAM.
REQ-002 SHALL have parameter PROM_AW, 10, PROM address width.
REQ-003 SHALL have port clk  in  1  system clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  in  1  reset; one clock, reset asynchronous and active-low.
REQ-005 SHALL have port downloading  in  1  ROM download window active.
REQ-006 SHALL have port ioctl_addr  in  22  byte address of the download stream.
REQ-007 SHALL have port ioctl_data  in  8  download byte.
REQ-008 SHALL have port ioctl_wr  in  1  one-cycle byte-valid strobe.
REQ-009 SHALL have port prog_addr  out  22  SDRAM word address.
REQ-010 SHALL have port prog_data  out  8  byte to write.
REQ-011 SHALL have port prog_mask  out  2  active-low byte mask: 2'b10 writes the low byte, 2'b01 writes the high byte.
REQ-012 SHALL have port prog_we  out  1  write request, level, held until acknowledged.
REQ-013 SHALL have port prog_ack  in  1  one-cycle SDRAM write-complete pulse.
REQ-014 SHALL have port prom_we  out  1  one-cycle PROM write strobe.
REQ-015 SHALL have ports prom_addr  out  PROM_AW  and prom_data  out  8, PROM target address and data.
REQ-016 SHALL have port overrun  out  1  sticky error: a byte was dropped.
REQ-017 SHALL have port dwnld_done  out  1  one-cycle pulse at the end of download.

Function
REQ-018 SHALL accept a byte only when ioctl_wr=1 and downloading=1; otherwise ioctl_wr is ignored.
REQ-019 SHALL classify a byte as PROM when ioctl_addr >= PROM_START, otherwise as SDRAM.
REQ-020 PROM byte: prom_we SHALL pulse for one cycle at N+1, where N is the ioctl_wr cycle, with prom_addr = (ioctl_addr-PROM_START) truncated to PROM_AW bits, prom_data = ioctl_data; no SDRAM activity.
REQ-021 SDRAM byte: prog_addr = {1'b0, ioctl_addr[21:1]}, prog_data = ioctl_data, prog_mask = ioctl_addr[0] ? 2'b01 : 2'b10.
REQ-022 FSM SHALL have states IDLE and WAIT_ACK.
REQ-023 IDLE with an SDRAM byte at cycle N: outputs SHALL be loaded and prog_we=1 at N+1; state SHALL become WAIT_ACK.
REQ-024 In WAIT_ACK, prog_we and prog_addr/data/mask SHALL hold until prog_ack=1; prog_we SHALL drop the cycle after ack.
REQ-025 A one-entry pending register SHALL capture an SDRAM byte that arrives in WAIT_ACK, including one arriving in the same cycle as prog_ack.
REQ-026 On ack with pending valid: prog_we SHALL stay low exactly one cycle, then reassert with the pending contents; pending SHALL clear and state SHALL remain WAIT_ACK.
REQ-027 On ack with pending empty: state SHALL become IDLE.
REQ-028 An SDRAM byte arriving while pending is valid, and not in an ack cycle, SHALL be dropped and SHALL set overrun; overrun clears only on reset.
REQ-029 prog_ack in IDLE SHALL be ignored.
REQ-030 A falling edge of downloading SHALL arm done; dwnld_done SHALL pulse once at the first cycle with state IDLE, pending empty and downloading=0.
REQ-031 A rising edge of downloading SHALL disarm done.
REQ-032 PROM strobes SHALL not be blocked by an outstanding SDRAM write.

Reset
REQ-033 rst_n=0 SHALL asynchronously clear: prog_we, prom_we, overrun, dwnld_done, pending valid, done arm; FSM to IDLE; prog_addr, prog_data and prom_addr to 0; prog_mask to 2'b11.
REQ-034 Reset mid-write SHALL discard the outstanding and pending bytes; a later prog_ack SHALL be ignored.

Configuration
REQ-035 With JTGNG_DWNLD_CHECKSUM_EN defined, the block SHALL add output chksum[15:0]: running modulo-2^16 sum of every accepted byte (SDRAM and PROM, dropped bytes excluded), cleared on reset and on rising edge of downloading, stable while downloading=0.
REQ-036 Without JTGNG_DWNLD_CHECKSUM_EN, the block SHALL have no chksum port and no summing logic.

Verification
REQ-037 ioctl_addr=22'h000003, data 8'hA5, wr at N -> at N+1 prog_we=1, prog_addr=22'h000001, prog_mask=2'b01, prog_data=8'hA5; ack at N+4 -> prog_we=0 at N+5.
REQ-038 Bytes at 0x10 and 0x11 two cycles apart, ack 5 cycles after first prog_we -> second write issued after a one-cycle prog_we low gap, mask 2'b01, overrun=0.
REQ-039 Three SDRAM bytes on consecutive cycles, no ack -> third dropped, overrun=1, first write still held.
REQ-040 ioctl_addr=22'h018005, data 8'h3C -> prom_we one cycle, prom_addr=10'h005, prom_data=8'h3C, prog_we unchanged.
REQ-041 downloading falls while a write is outstanding -> dwnld_done=0 until the ack; pulse exactly one cycle after return to IDLE.
REQ-042 rst_n low in WAIT_ACK -> all outputs at reset values immediately; ack after release -> no prog_we.
